// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator with a pixel-tick divider and a
// PIPE-deep sync/blank delay line that keeps outputs aligned to rgb_in.
module vga_timing_pipe #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0,
    parameter int CLK_DIV   = 4,
    parameter int PIPE      = 1,
    parameter int CW        = 10,
    parameter int RGB_W     = 12
) (
    input  logic             clk_100Mhz,
    input  logic             reset,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             p_tick,
    output logic [CW-1:0]    x,
    output logic [CW-1:0]    y,
    output logic             line_start,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [RGB_W-1:0] rgb_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW:0]   H_LAST   = (CW+1)'(H_TOTAL - 1);
    localparam logic [CW:0]   V_LAST   = (CW+1)'(V_TOTAL - 1);
    localparam logic [CW:0]   H_VIS    = (CW+1)'(H_DISPLAY);
    localparam logic [CW:0]   V_VIS    = (CW+1)'(V_DISPLAY);
    localparam logic [CW:0]   HS_BEG   = (CW+1)'(H_DISPLAY + H_FRONT);
    localparam logic [CW:0]   HS_END   = (CW+1)'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CW:0]   VS_BEG   = (CW+1)'(V_DISPLAY + V_FRONT);
    localparam logic [CW:0]   VS_END   = (CW+1)'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic          POL      = (SYNC_POL != 0);

    generate
        if (H_TOTAL > (1 << CW)) begin : g_h_range
            $error("H_TOTAL does not fit in CW bits");
        end
        if (V_TOTAL > (1 << CW)) begin : g_v_range
            $error("V_TOTAL does not fit in CW bits");
        end
        if (CLK_DIV < 1 || PIPE < 1) begin : g_cfg
            $error("CLK_DIV and PIPE must be at least 1");
        end
    endgenerate

    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             p_tick_q, p_tick_d;
    logic [CW-1:0]    h_cnt_q, h_cnt_d;
    logic [CW-1:0]    v_cnt_q, v_cnt_d;
    logic [PIPE-1:0]  vid_q, vid_d;
    logic [PIPE-1:0]  hs_q, hs_d;
    logic [PIPE-1:0]  vs_q, vs_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    logic [CW:0] h_ext, v_ext;
    logic        h_last, v_last;
    logic        vid_raw, hs_raw, vs_raw;

    always_comb begin
        h_ext   = {1'b0, h_cnt_q};
        v_ext   = {1'b0, v_cnt_q};
        h_last  = (h_ext == H_LAST);
        v_last  = (v_ext == V_LAST);
        vid_raw = (h_ext < H_VIS) && (v_ext < V_VIS);
        hs_raw  = (h_ext >= HS_BEG) && (h_ext < HS_END);
        vs_raw  = (v_ext >= VS_BEG) && (v_ext < VS_END);

        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        p_tick_d  = (div_cnt_q == DIV_LAST);

        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        vid_d   = vid_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        rgb_d   = rgb_q;

        if (p_tick_q) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
            if (h_last) begin
                v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
            end
            vid_d[0] = vid_raw;
            hs_d[0]  = hs_raw;
            vs_d[0]  = vs_raw;
            for (int i = 1; i < PIPE; i++) begin
                vid_d[i] = vid_q[i-1];
                hs_d[i]  = hs_q[i-1];
                vs_d[i]  = vs_q[i-1];
            end
            // colour is masked by the flag entering the final stage
            rgb_d = vid_d[PIPE-1] ? rgb_in : '0;
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            div_cnt_q <= '0;
            p_tick_q  <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            vid_q     <= '0;
            hs_q      <= '0;
            vs_q      <= '0;
            rgb_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            p_tick_q  <= p_tick_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            vid_q     <= vid_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            rgb_q     <= rgb_d;
        end
    end

    assign p_tick      = p_tick_q;
    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign line_start  = p_tick_q && h_last;
    assign frame_start = line_start && v_last;
    assign video_on    = vid_q[PIPE-1];
    assign hsync       = hs_q[PIPE-1] ? POL : ~POL;
    assign vsync       = vs_q[PIPE-1] ? POL : ~POL;
    assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench: default geometry, a small PIPE=2 geometry with a
// registered pattern source, and a tiny CLK_DIV=1 / PIPE=3 corner.
module tb_vga_timing_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int orphans = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // default instance
    logic        rst_d;
    logic [11:0] d_rgb_in = 12'hABC;
    logic        d_p_tick, d_ls, d_fs, d_hs, d_vs, d_vid;
    logic [9:0]  d_x, d_y;
    logic [11:0] d_rgb;

    vga_timing_pipe u_def (
        .clk_100Mhz(clk), .reset(rst_d), .rgb_in(d_rgb_in),
        .p_tick(d_p_tick), .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_vid), .rgb_out(d_rgb)
    );

    // PIPE=2 instance, H=8/2/3/3, V=6/1/2/1, CLK_DIV=2
    logic        rst_p;
    logic [11:0] p_src;
    logic        p_p_tick, p_ls, p_fs, p_hs, p_vs, p_vid;
    logic [9:0]  p_x, p_y;
    logic [11:0] p_rgb;

    vga_timing_pipe #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(2), .PIPE(2)
    ) u_pip (
        .clk_100Mhz(clk), .reset(rst_p), .rgb_in(p_src),
        .p_tick(p_p_tick), .x(p_x), .y(p_y),
        .line_start(p_ls), .frame_start(p_fs),
        .hsync(p_hs), .vsync(p_vs), .video_on(p_vid), .rgb_out(p_rgb)
    );

    always_ff @(posedge clk) begin
        if (p_p_tick) p_src <= {p_x[3:0], p_y[3:0], 4'hF};
    end

    // corner instance
    logic        rst_c;
    logic [11:0] c_rgb_in = 12'h5A5;
    logic        c_p_tick, c_ls, c_fs, c_hs, c_vs, c_vid;
    logic [9:0]  c_x, c_y;
    logic [11:0] c_rgb;

    vga_timing_pipe #(
        .H_DISPLAY(4), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1), .CLK_DIV(1), .PIPE(3)
    ) u_cor (
        .clk_100Mhz(clk), .reset(rst_c), .rgb_in(c_rgb_in),
        .p_tick(c_p_tick), .x(c_x), .y(c_y),
        .line_start(c_ls), .frame_start(c_fs),
        .hsync(c_hs), .vsync(c_vs), .video_on(c_vid), .rgb_out(c_rgb)
    );

    always @(negedge clk) begin
        if ((d_ls && !d_p_tick) || (d_fs && !d_ls) ||
            (p_ls && !p_p_tick) || (p_fs && !p_ls) ||
            (c_ls && !c_p_tick) || (c_fs && !c_ls))
            orphans++;
    end

    task automatic chk_def_reset(input string pfx);
        chk({pfx, "_x"}, d_x, 0);
        chk({pfx, "_y"}, d_y, 0);
        chk({pfx, "_ptick"}, d_p_tick, 0);
        chk({pfx, "_ls"}, d_ls, 0);
        chk({pfx, "_fs"}, d_fs, 0);
        chk({pfx, "_vid"}, d_vid, 0);
        chk({pfx, "_rgb"}, d_rgb, 0);
        chk({pfx, "_hs"}, d_hs, 1);
        chk({pfx, "_vs"}, d_vs, 1);
    endtask

    task automatic first_tick_def(input string tag);
        int first;
        first = -1;
        rst_d = 1'b0;
        for (int i = 1; i <= 10 && first < 0; i++) begin
            @(negedge clk);
            if (d_p_tick) first = i;
        end
        chk(tag, first, 4);
    endtask

    int hx[320];
    int vy[320];

    initial begin
        int found, tk, hs_ticks, hs_clks, vid_ticks, hfall, vrise, xbad;
        bit prev_hs, prev_vid;
        int ph, pv, xyb, vidb, rgbb, syncb, holdb, act, fsc, fss, fsx, fsy;
        logic [11:0] exp_rgb, held;
        logic e_vid, e_hs, e_vs;
        int ptc, lsc, lsb, lsp, fsc2, fsp, fsd, hsb, vsb;

        rst_d = 1'b1;
        rst_p = 1'b1;
        rst_c = 1'b1;
        repeat (3) @(negedge clk);

        // ---------------- default geometry ----------------
        chk_def_reset("rst0");
        first_tick_def("def_first_tick");

        found = 0;
        for (int k = 0; k < 4000 && found == 0; k++) begin
            @(negedge clk);
            if (d_p_tick && d_ls) found = 1;
        end
        chk("def_ls_seen", found, 1);

        hs_ticks = 0; hs_clks = 0; vid_ticks = 0;
        hfall = -1; vrise = -1; xbad = 0;
        prev_hs = d_hs; prev_vid = d_vid;
        for (int i = 0; i < 800; i++) begin
            tk = 0;
            for (int k = 0; k < 8 && tk == 0; k++) begin
                @(negedge clk);
                if (!d_hs) hs_clks++;
                tk = d_p_tick;
            end
            if (d_x != 10'(i)) xbad++;
            if (!d_hs) hs_ticks++;
            if (d_vid) vid_ticks++;
            if (prev_hs && !d_hs && hfall < 0) hfall = i;
            if (!prev_vid && d_vid && vrise < 0) vrise = i;
            prev_hs = d_hs;
            prev_vid = d_vid;
        end
        chk("def_line_x_bad", xbad, 0);
        chk("def_hs_low_ticks", hs_ticks, 96);
        chk("def_hs_low_clks", hs_clks, 384);
        chk("def_vid_ticks", vid_ticks, 640);
        chk("def_hs_fall_x", hfall, 656 + 1);
        chk("def_vid_rise_x", vrise, 0 + 1);

        found = 0;
        for (int k = 0; k < 2000 && found == 0; k++) begin
            @(negedge clk);
            if (d_p_tick && d_x == 10'd300) found = 1;
        end
        chk("def_x300_seen", found, 1);
        chk("def_y_before_rst", d_y, 2);
        chk("def_vid_at_300", d_vid, 1);
        chk("def_rgb_at_300", d_rgb, 12'hABC);
        rst_d = 1'b1;
        repeat (10) @(negedge clk);
        chk_def_reset("rst1");
        first_tick_def("def_first_tick2");

        // ---------------- PIPE=2 alignment ----------------
        rst_p = 1'b0;
        found = -1;
        for (int i = 1; i <= 10 && found < 0; i++) begin
            @(negedge clk);
            if (p_p_tick) found = i;
        end
        chk("pip_first_tick", found, 2);

        xyb = 0; vidb = 0; rgbb = 0; syncb = 0; holdb = 0;
        act = 0; fsc = 0; fss = -1; fsx = -1; fsy = -1;
        held = p_rgb;
        for (int s = 0; s < 320; s++) begin
            if (s > 0) begin
                tk = 0;
                for (int k = 0; k < 4 && tk == 0; k++) begin
                    @(negedge clk);
                    tk = p_p_tick;
                    if (!tk) held = p_rgb;
                end
                if (p_rgb !== held) holdb++;
            end
            hx[s] = s % 16;
            vy[s] = (s / 16) % 10;
            if (p_x != 10'(hx[s]) || p_y != 10'(vy[s])) xyb++;
            if (s >= 2) begin
                ph = hx[s-2];
                pv = vy[s-2];
                e_vid = (ph < 8) && (pv < 6);
                e_hs = !((ph >= 10) && (ph < 13));
                e_vs = !((pv >= 7) && (pv < 9));
                exp_rgb = e_vid ? {4'(ph), 4'(pv), 4'hF} : 12'h000;
            end else begin
                e_vid = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
                exp_rgb = 12'h000;
            end
            if (p_vid !== e_vid) vidb++;
            if (p_rgb !== exp_rgb) rgbb++;
            if (p_hs !== e_hs || p_vs !== e_vs) syncb++;
            if (p_rgb != 12'h000) act++;
            if (p_fs) begin
                fsc++; fss = s; fsx = int'(p_x); fsy = int'(p_y);
            end
        end
        chk("pip_xy_bad", xyb, 0);
        chk("pip_vid_bad", vidb, 0);
        chk("pip_rgb_bad", rgbb, 0);
        chk("pip_sync_bad", syncb, 0);
        chk("pip_hold_bad", holdb, 0);
        chk("pip_active_px", act, 96);
        chk("pip_fs_count", fsc, 2);
        chk("pip_fs_sample", fss, 319);
        chk("pip_fs_x", fsx, 15);
        chk("pip_fs_y", fsy, 9);

        // ---------------- corner configuration ----------------
        rst_c = 1'b0;
        ptc = 0; xyb = 0; hsb = 0; vsb = 0; vidb = 0;
        lsc = 0; lsb = 0; lsp = -1; fsc2 = 0; fsp = -1; fsd = -1;
        for (int s = 0; s < 120; s++) begin
            @(negedge clk);
            if (c_p_tick) ptc++;
            if (c_x != 10'(s % 10) || c_y != 10'((s / 10) % 6)) xyb++;
            if (s >= 3) begin
                ph = (s - 3) % 10;
                pv = ((s - 3) / 10) % 6;
                e_hs = (ph >= 6) && (ph < 8);
                e_vs = (pv == 4);
                e_vid = (ph < 4) && (pv < 3);
            end else begin
                e_hs = 1'b0; e_vs = 1'b0; e_vid = 1'b0;
            end
            if (c_hs !== e_hs) hsb++;
            if (c_vs !== e_vs) vsb++;
            if (c_vid !== e_vid || c_rgb !== (e_vid ? 12'h5A5 : 12'h000))
                vidb++;
            if (c_ls) begin
                lsc++;
                if (lsp >= 0 && s - lsp != 10) lsb++;
                lsp = s;
            end
            if (c_fs) begin
                fsc2++;
                if (fsp >= 0) fsd = s - fsp;
                fsp = s;
            end
        end
        chk("cor_ptick_cnt", ptc, 120);
        chk("cor_xy_bad", xyb, 0);
        chk("cor_hs_bad", hsb, 0);
        chk("cor_vs_bad", vsb, 0);
        chk("cor_vid_bad", vidb, 0);
        chk("cor_ls_cnt", lsc, 12);
        chk("cor_ls_period_bad", lsb, 0);
        chk("cor_fs_cnt", fsc2, 2);
        chk("cor_fs_period", fsd, 60);

        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            @(negedge clk);
            if (c_hs && c_vs) found = 1;
        end
        chk("cor_sync_seen", found, 1);
        rst_c = 1'b1;
        @(negedge clk);
        chk("cor_rst_hs", c_hs, 0);
        chk("cor_rst_vs", c_vs, 0);
        chk("cor_rst_xy", {c_x, c_y}, 0);
        @(negedge clk);
        rst_c = 1'b0;
        hsb = 0;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            if (s < 9 && c_hs) hsb++;
            if (s == 0) chk("cor_rel_rgb0", c_rgb, 0);
            if (s == 3) chk("cor_rel_rgb3", c_rgb, 12'h5A5);
            if (s == 9) chk("cor_rel_hs9", c_hs, 1);
        end
        chk("cor_no_glitch", hsb, 0);

        chk("strobe_orphans", orphans, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
